// File: rtl/decode_pkg.sv
// Shared decode-stage constants: producer latencies, latency type, zero register.
package decode_pkg;

  localparam int unsigned LAT_W = 3;

  typedef logic [LAT_W-1:0] lat_t;

  localparam lat_t LAT_ALU  = 3'd1;
  localparam lat_t LAT_LOAD = 3'd2;
  localparam lat_t LAT_MUL  = 3'd4;
  localparam lat_t LAT_COPR = 3'd1;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/decode_scoreboard_if.sv
// Decode <-> scoreboard bundle: instruction operands, pipeline controls, hazard results.
interface decode_scoreboard_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS       = 1 << REG_ADDR_WIDTH,
  parameter int unsigned LAT_WIDTH      = 3,
  parameter int unsigned NUM_SRC        = 2
);
  localparam int unsigned STALL_CNT_W = 16;

  logic                             i_valid;
  logic [NUM_SRC-1:0]               i_src_en;
  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] i_src_addr;
  logic                             i_dst_en;
  logic [REG_ADDR_WIDTH-1:0]        i_dst_addr;
  logic [LAT_WIDTH-1:0]             i_dst_lat;
  logic                             i_hold;
  logic                             i_kill;
  logic                             i_flush;
  logic                             o_stall;
  logic                             o_issue;
  logic [NUM_SRC-1:0]               o_src_fwd;
  logic [NUM_REGS-1:0]              o_busy_mask;
  logic [STALL_CNT_W-1:0]           o_stall_cnt;

  // Decode side: presents the instruction, observes the verdict.
  modport master (
    output i_valid, i_src_en, i_src_addr, i_dst_en, i_dst_addr, i_dst_lat,
           i_hold, i_kill, i_flush,
    input  o_stall, o_issue, o_src_fwd, o_busy_mask, o_stall_cnt
  );

  // Scoreboard side.
  modport slave (
    input  i_valid, i_src_en, i_src_addr, i_dst_en, i_dst_addr, i_dst_lat,
           i_hold, i_kill, i_flush,
    output o_stall, o_issue, o_src_fwd, o_busy_mask, o_stall_cnt
  );

endinterface

// File: rtl/decode_scoreboard_sb_entry.sv
// One register's pending-write countdown: load on issue, decrement per free cycle,
// clear on flush, freeze on hold.
module sb_entry #(
  parameter int unsigned LAT_WIDTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic                 load,
  input  logic [LAT_WIDTH-1:0] load_val,
  input  logic                 flush,
  input  logic                 hold,
  output logic [LAT_WIDTH-1:0] cnt,
  output logic                 zero_c
);

  assign zero_c = (cnt == '0);

  // Flush beats everything; a new issue beats the decrement of the same entry.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (!hold) begin
      if (load) begin
        cnt <= load_val;
      end else if (!zero_c) begin
        cnt <= cnt - LAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage register scoreboard with per-register countdown counters.
// Optional macro DECODE_SB_FWD_EN: sources one cycle from ready take the bypass
// instead of stalling.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS       = 1 << REG_ADDR_WIDTH,
  parameter int unsigned LAT_WIDTH      = LAT_W,
  parameter int unsigned NUM_SRC        = 2
) (
  input logic                i_clk,
  input logic                i_arst_n,
  decode_scoreboard_if.slave sb
);

`ifdef DECODE_SB_FWD_EN
  localparam int unsigned THR = 1;
`else
  localparam int unsigned THR = 0;
`endif
  localparam int unsigned STALL_CNT_W = 16;

  logic [NUM_REGS-1:0][LAT_WIDTH-1:0] cnt;
  logic [NUM_REGS-1:0]                zero_c;
  logic [NUM_SRC-1:0][LAT_WIDTH-1:0]  src_cnt;
  logic [LAT_WIDTH-1:0]               dst_cnt;
  logic [NUM_SRC-1:0]                 src_haz;
  logic [NUM_SRC-1:0]                 src_fwd;
  logic                               waw_haz;
  logic                               stall;
  logic                               issue;
  logic [STALL_CNT_W-1:0]             stall_cnt;

  // Register 0 is never pending.
  assign cnt[0]    = '0;
  assign zero_c[0] = 1'b1;

  // One countdown entry per tracked register.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    logic load_r;
    assign load_r = issue & sb.i_dst_en & (sb.i_dst_lat != '0)
                  & (sb.i_dst_addr == REG_ADDR_WIDTH'(r));
    sb_entry #(.LAT_WIDTH(LAT_WIDTH)) u_entry (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .load     (load_r),
      .load_val (sb.i_dst_lat),
      .flush    (sb.i_flush),
      .hold     (sb.i_hold),
      .cnt      (cnt[r]),
      .zero_c   (zero_c[r])
    );
  end

  // Counter value seen by each source operand.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign src_cnt[k] = cnt[sb.i_src_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
  end

  assign dst_cnt = cnt[sb.i_dst_addr];

  // Source/WAW hazards, bypass select, stall and issue decisions.
  always_comb begin
    src_haz = '0;
    src_fwd = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      src_haz[k] = sb.i_valid & sb.i_src_en[k] & (src_cnt[k] > LAT_WIDTH'(THR));
`ifdef DECODE_SB_FWD_EN
      src_fwd[k] = sb.i_valid & sb.i_src_en[k] & ~sb.i_kill
                 & (src_cnt[k] == LAT_WIDTH'(1));
`endif
    end
    waw_haz = sb.i_valid & sb.i_dst_en & (dst_cnt > sb.i_dst_lat)
            & (sb.i_dst_addr != REG_ADDR_WIDTH'(REG_ZERO));
    stall   = ((|src_haz) | waw_haz) & ~sb.i_kill;
    issue   = sb.i_valid & ~stall & ~sb.i_hold & ~sb.i_kill;
  end

  // Saturating count of cycles lost to hazards while the pipe is moving.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      stall_cnt <= '0;
    end else if (stall && !sb.i_hold && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign sb.o_stall     = stall;
  assign sb.o_issue     = issue;
  assign sb.o_src_fwd   = src_fwd;
  assign sb.o_busy_mask = ~zero_c;
  assign sb.o_stall_cnt = stall_cnt;

endmodule

// File: doc/decode_scoreboard.md
# decode_scoreboard

Parametrised register scoreboard for the decode stage. It replaces the fixed three-stage write-address comparison with per-register countdown counters, so producers of any latency up to `2^LAT_WIDTH-1` cycles can coexist. The block sits between the register-file read and the decode output registers. It issues `o_stall` (load nop) while any source or destination hazard is open, and flags sources that must take the bypass path.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5: GPR address width.
- `NUM_REGS`, `1 << REG_ADDR_WIDTH`: tracked registers; register 0 is never tracked.
- `LAT_WIDTH`, 3: producer latency field width.
- `NUM_SRC`, 2: source operands per instruction.

Ports:
- `i_clk`  in  1  clock.
- `i_arst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  decode holds a valid instruction.
- `i_src_en`  in  NUM_SRC  per-source read enable.
- `i_src_addr`  in  NUM_SRC*REG_ADDR_WIDTH  source addresses; source k is in bits `[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]`.
- `i_dst_en`  in  1  instruction writes a GPR.
- `i_dst_addr`  in  REG_ADDR_WIDTH  destination address.
- `i_dst_lat`  in  LAT_WIDTH  cycles from issue until the result is readable from the register file.
- `i_hold`  in  1  pipeline frozen by execute; no issue, no countdown.
- `i_kill`  in  1  interrupt or wrong instruction; cancels this cycle's issue.
- `i_flush`  in  1  clear all counters (pipeline drained after exception).
- `o_stall`  out  1  hazard; decode must load nop.
- `o_issue`  out  1  instruction accepted this cycle.
- `o_src_fwd`  out  NUM_SRC  source k must use the bypass value.
- `o_busy_mask`  out  NUM_REGS  bit r set when cnt[r] != 0.
- `o_stall_cnt`  out  16  saturating count of stall cycles.

## Operation
- State: `cnt[r]` is LAT_WIDTH bits for r = 1..NUM_REGS-1. `cnt[0]` is hard-wired to 0.
- Source hazard on source k: `i_valid & i_src_en[k] & (cnt[src_k] > THR)`. THR is set in Configuration.
- WAW hazard: `i_valid & i_dst_en & (cnt[dst] > i_dst_lat)`. This keeps an older write from landing after a younger one.
- `o_stall` is the OR of all source and WAW hazards. It is forced to 0 when `i_kill` is high.
- `o_issue = i_valid & ~o_stall & ~i_hold & ~i_kill`.
- On issue with `i_dst_en`, `i_dst_addr != 0` and `i_dst_lat != 0`: `cnt[dst] <= i_dst_lat`. The issue load takes priority over decrement of the same entry.
- `i_dst_lat == 0` is treated as untracked; no counter is written.
- Every cycle with `~i_hold`, each other nonzero counter decrements by 1. Counters saturate at 0, with no wrap.
- `i_hold` freezes all counters. Issue is blocked, `o_stall` is still computed, and `o_stall_cnt` does not count.
- `i_flush` clears every counter. It has priority over issue and decrement in the same cycle.
- `o_stall_cnt` increments when `o_stall & ~i_hold` and saturates at 16'hFFFF.
- Sources or destinations addressing register 0 never stall.

## Timing
- `o_stall`, `o_issue` and `o_src_fwd` are combinational from registered counters and the current inputs; zero latency.
- Counter updates take effect on the next `i_clk` rising edge.
- Dependent-instruction example: issue with lat L at cycle t, so cnt = L at t+1.
  - Without forwarding, a dependent instruction issues at t+1+L.
  - With forwarding, it issues at t+L with the fwd flag set.
- Reset: all cnt = 0, `o_stall_cnt` = 0.
  - Derived outputs at reset: `o_busy_mask` = 0, `o_stall` = 0, `o_src_fwd` = 0, `o_issue` = `i_valid & ~i_hold & ~i_kill`.
- Reset asserted mid-operation discards all pending entries immediately (asynchronous).

## Configuration
- Macro `DECODE_SB_FWD_EN`.
- Defined: THR = 1. `o_src_fwd[k]` is high when `cnt[src_k] == 1` with the source enabled, `i_valid` high and `i_kill` low.
- Undefined: THR = 0, so any pending write stalls. `o_src_fwd` is tied to 0.

## Structure
- Shared package `decode_pkg`:
  - latency constants `LAT_ALU` = 1, `LAT_LOAD` = 2, `LAT_MUL` = 4, `LAT_COPR` = 1;
  - `lat_t` typedef;
  - `REG_ZERO` = 0.
- One sub-module, `sb_entry`: a single register's counter with load, decrement, flush, hold and a zero flag. It is instantiated NUM_REGS-1 times via generate.

## Test plan
- Reset, then source 0 = r3 with `i_valid` → `o_stall`=0, `o_issue`=1, `o_busy_mask`=0, `o_stall_cnt`=0.
- Issue dst r5 with lat 2; next cycle source 0 = r5.
  - Without fwd: `o_stall`=1 for 2 cycles, then `o_issue`=1, and `o_stall_cnt` ends at 2.
  - With fwd: `o_stall`=1 for 1 cycle, then `o_issue`=1 with `o_src_fwd[0]`=1.
- Issue dst r7 with lat 4; next cycle dst r7 with lat 1 → WAW stall while cnt[r7] is 4, 3 or 2 (3 cycles, no fwd dependency). It issues when cnt = 1, and cnt[r7] then reloads to 1.
- cnt[r9]=3, `i_hold` high for 5 cycles → cnt[r9] stays 3 and `o_stall_cnt` is unchanged. After release, it decrements 3, 2, 1, 0.
- Hazard on r4 with `i_kill`=1 → `o_stall`=0, `o_issue`=0, no counter written.
- `i_flush` in the same cycle as an issue to r6 with lat 3 → all cnt = 0 and `o_busy_mask`=0 next cycle.
- Destination r0 with lat 4 → `o_busy_mask`=0 and no later stall on r0.
